// File: rtl/prewish_multiblinky.sv
// prewish_multiblinky: NUM_CH double-buffered LED pattern players on a shared tick.
// Define PREWISH_MULTIBLINKY_PWM_EN to add per-channel PWM dimming via i_duty.
module prewish_multiblinky #(
   parameter int NUM_CH        = 4,
   parameter int CH_BITS       = 2,
   parameter int MASK_BITS     = 8,
   parameter int PRESCALE_BITS = 20
`ifdef PREWISH_MULTIBLINKY_PWM_EN
   ,
   parameter int PWM_BITS      = 4
`endif
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_stb,
   input  logic [CH_BITS-1:0]   i_ch,
   input  logic [MASK_BITS-1:0] i_dat,
   input  logic                 i_mode,
`ifdef PREWISH_MULTIBLINKY_PWM_EN
   input  logic [PWM_BITS-1:0]  i_duty,
`endif
   output logic                 o_ack,
   output logic                 o_tick,
   output logic [NUM_CH-1:0]    o_busy,
   output logic [NUM_CH-1:0]    o_led
);
   localparam int IW = $clog2(MASK_BITS);
   localparam logic [IW-1:0] LAST = IW'(MASK_BITS - 1);

   typedef enum logic {IDLE, RUN} state_t;

   logic [PRESCALE_BITS-1:0] pre_cnt;
   logic                     stb_q;
   logic                     stb_edge;
   logic                     ld;

   assign o_tick   = &pre_cnt;
   assign stb_edge = i_stb & ~stb_q;
   assign ld       = stb_edge && (32'(i_ch) < NUM_CH);

`ifdef PREWISH_MULTIBLINKY_PWM_EN
   logic [PWM_BITS-1:0] pwm_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) pwm_cnt <= '0;
      else          pwm_cnt <= pwm_cnt + PWM_BITS'(1);
   end
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pre_cnt <= '0;
         stb_q   <= 1'b0;
         o_ack   <= 1'b0;
      end else begin
         pre_cnt <= pre_cnt + PRESCALE_BITS'(1);
         stb_q   <= i_stb;
         o_ack   <= ld;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      state_t                 state, n_state;
      logic [MASK_BITS-1:0]   pending, active, n_active;
      logic                   pmode, mode, n_mode;
      logic                   pvalid, take, ld_me;
      logic [IW-1:0]          idx, n_idx;
      logic                   n_bit, led_q;
`ifdef PREWISH_MULTIBLINKY_PWM_EN
      logic [PWM_BITS-1:0]    pduty, duty, n_duty;
      logic                   gate;
`endif

      assign ld_me = ld && (i_ch == CH_BITS'(c));

      always_comb begin
         n_state  = state;
         n_idx    = idx;
         n_active = active;
         n_mode   = mode;
         take     = 1'b0;
         if (o_tick) begin
            unique case (state)
               IDLE: take = pvalid;
               RUN: begin
                  if (idx != LAST) n_idx = idx + IW'(1);
                  else if (pvalid) take = 1'b1;
                  else if (mode)   n_idx = '0;
                  else             n_state = IDLE;
               end
            endcase
         end
         if (take) begin
            n_state  = RUN;
            n_active = pending;
            n_mode   = pmode;
            n_idx    = '0;
         end
         // LED register tracks the bit selected by the next state
         n_bit = (n_state == RUN) & n_active[LAST - n_idx];
`ifdef PREWISH_MULTIBLINKY_PWM_EN
         n_duty = take ? pduty : duty;
         gate   = (&n_duty) || (pwm_cnt < n_duty);
`endif
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            active  <= '0;
            mode    <= 1'b0;
            pending <= '0;
            pmode   <= 1'b0;
            pvalid  <= 1'b0;
            led_q   <= 1'b0;
`ifdef PREWISH_MULTIBLINKY_PWM_EN
            pduty   <= '0;
            duty    <= '0;
`endif
         end else begin
            state  <= n_state;
            idx    <= n_idx;
            active <= n_active;
            mode   <= n_mode;
`ifdef PREWISH_MULTIBLINKY_PWM_EN
            duty   <= n_duty;
            led_q  <= n_bit & gate;
`else
            led_q  <= n_bit;
`endif
            if (take) pvalid <= 1'b0;
            // a same-cycle load lands after the boundary consumed the old one
            if (ld_me) begin
               pending <= i_dat;
               pmode   <= i_mode;
               pvalid  <= 1'b1;
`ifdef PREWISH_MULTIBLINKY_PWM_EN
               pduty   <= i_duty;
`endif
            end
         end
      end

      assign o_busy[c] = (state == RUN);
      assign o_led[c]  = led_q;
   end

endmodule
